// File: rtl/tracking_loop_ram_ctrl.sv
// Tracking-loop state RAM sequencer.
// Port A runs a per-channel read-modify-write for the loop update logic,
// port B serves host/debug accesses. Host accesses to the channel under
// update are stalled, so the RAM never sees a mixed-port read-during-write.
module tracking_loop_ram_ctrl #(
    parameter int DEPTH      = 12,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    // tracking-loop request / result
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_chan,
    output logic                  req_ready,
    output logic                  req_err,
    output logic                  state_valid,
    output logic [DATA_WIDTH-1:0] state_data,
    input  logic                  upd_valid,
    input  logic                  upd_discard,
    input  logic [DATA_WIDTH-1:0] upd_data,
    output logic                  done,
    output logic                  busy,
    output logic [15:0]           update_count,
    // host / debug access
    input  logic                  host_req,
    input  logic                  host_wr,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    // dual-port RAM (registered address and output, 2-cycle read latency)
    output logic [ADDR_WIDTH-1:0] ram_address_a,
    output logic [ADDR_WIDTH-1:0] ram_address_b,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic [DATA_WIDTH-1:0] ram_data_b,
    output logic                  ram_wren_a,
    output logic                  ram_wren_b,
    input  logic [DATA_WIDTH-1:0] ram_q_a,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_CAPTURE,
        S_UPDATE,
        S_WRITE
    } state_t;

    // One extra bit so DEPTH == 2^ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_locked_chan;
    logic [DATA_WIDTH-1:0] r_upd_data;
    logic [DATA_WIDTH-1:0] r_state_data;
    logic                  r_first_upd;
    logic [15:0]           r_update_count;
    logic [1:0]            r_rd_pipe;
    logic [1:0]            r_oor_pipe;

    logic                  w_req_in_range;
    logic                  w_host_in_range;
    logic                  w_accept;
    logic                  w_lock_active;
    logic [ADDR_WIDTH-1:0] w_lock_addr;
    logic                  w_latch_upd;

    assign w_req_in_range  = ({1'b0, req_chan} < C_DEPTH);
    assign w_host_in_range = ({1'b0, host_addr} < C_DEPTH);
    assign w_accept        = (r_state == S_IDLE) && req_valid && w_req_in_range;

    // The lock already covers req_chan in the accept cycle, so a host access
    // to the same channel in that cycle loses to the tracking request.
    assign w_lock_active = w_accept || (r_state != S_IDLE);
    assign w_lock_addr   = w_accept ? req_chan : r_locked_chan;

    assign host_ack   = host_req && !(w_lock_active && (host_addr == w_lock_addr));
    assign ram_address_b = host_ack ? host_addr  : '0;
    assign ram_data_b    = host_ack ? host_wdata : '0;
    // Out-of-range host writes are acked but never reach the RAM.
    assign ram_wren_b    = host_ack && host_wr && w_host_in_range;

    assign ram_address_a = r_locked_chan;
    assign ram_data_a    = r_upd_data;
    assign busy          = (r_state != S_IDLE);
    assign state_data    = r_state_data;
    assign update_count  = r_update_count;
    assign host_rvalid   = r_rd_pipe[1];
    assign host_rdata    = (r_rd_pipe[1] && !r_oor_pipe[1]) ? ram_q_b : '0;

    // FSM state register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state control strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_next_state = r_state;
        req_ready    = 1'b0;
        req_err      = 1'b0;
        state_valid  = 1'b0;
        done         = 1'b0;
        ram_wren_a   = 1'b0;
        w_latch_upd  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_in_range) begin
                        w_next_state = S_READ;
                    end else begin
                        req_err = 1'b1;
                    end
                end
            end
            S_READ:    w_next_state = S_WAIT;
            S_WAIT:    w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_UPDATE;
            S_UPDATE: begin
                state_valid = r_first_upd;
                if (upd_valid) begin
                    if (upd_discard) begin
                        done         = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_latch_upd  = 1'b1;
                        w_next_state = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                ram_wren_a   = 1'b1;
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Channel lock, captured state word, write-back data and completion count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_locked_chan  <= '0;
            r_upd_data     <= '0;
            r_state_data   <= '0;
            r_first_upd    <= 1'b0;
            r_update_count <= '0;
        end else begin
            if (w_accept) begin
                r_locked_chan <= req_chan;
            end
            if (w_latch_upd) begin
                r_upd_data <= upd_data;
            end
            if (r_state == S_CAPTURE) begin
                r_state_data <= ram_q_a;
            end
            // High only during the first UPDATE cycle.
            r_first_upd <= (r_state == S_CAPTURE);
            if (r_state == S_WRITE) begin
                r_update_count <= r_update_count + 16'd1;
            end
        end
    end

    // Host read pipeline, aligned with the RAM's 2-cycle read latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pipe  <= '0;
            r_oor_pipe <= '0;
        end else begin
            r_rd_pipe  <= {r_rd_pipe[0], host_ack && !host_wr};
            r_oor_pipe <= {r_oor_pipe[0], !w_host_in_range};
        end
    end

endmodule

// File: tb/tb_tracking_loop_ram_ctrl.sv
// Bench for tracking_loop_ram_ctrl: behavioural dual-port RAM, a
// transaction-level reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic.
module tb_tracking_loop_ram_ctrl;

    localparam int DEPTH = 12;
    localparam int AW    = 4;
    localparam int DW    = 64;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_chan = '0;
    logic          req_ready, req_err, state_valid;
    logic [DW-1:0] state_data;
    logic          upd_valid = 1'b0;
    logic          upd_discard = 1'b0;
    logic [DW-1:0] upd_data = '0;
    logic          done, busy;
    logic [15:0]   update_count;
    logic          host_req = 1'b0;
    logic          host_wr = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_ack, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] ram_address_a, ram_address_b;
    logic [DW-1:0] ram_data_a, ram_data_b;
    logic          ram_wren_a, ram_wren_b;
    logic [DW-1:0] ram_q_a, ram_q_b;

    int n_checks = 0;
    int n_errors = 0;

    tracking_loop_ram_ctrl #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_chan(req_chan), .req_ready(req_ready), .req_err(req_err),
        .state_valid(state_valid), .state_data(state_data),
        .upd_valid(upd_valid), .upd_discard(upd_discard), .upd_data(upd_data),
        .done(done), .busy(busy), .update_count(update_count),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .ram_address_a(ram_address_a), .ram_address_b(ram_address_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_wren_a(ram_wren_a), .ram_wren_b(ram_wren_b),
        .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
    );

    initial forever #5 clock = ~clock;

    // ---------------- RAM: registered address, registered output ----------------
    logic [DW-1:0] mem  [0:15];
    logic [DW-1:0] gold [0:15];
    logic [AW-1:0] ra_a = '0, ra_b = '0;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]  = 64'h0C0F_FEE0_0000_0000 | 64'(i);
            gold[i] = 64'h0C0F_FEE0_0000_0000 | 64'(i);
        end
    end

    always @(posedge clock) begin
        ra_a    <= ram_address_a;
        ra_b    <= ram_address_b;
        ram_q_a <= mem[ra_a];
        ram_q_b <= mem[ra_b];
        if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
        if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (compare at negedge) ----------------
    bit            m_active, m_writing;
    int            m_age;
    logic [AW-1:0] m_chan;
    logic [DW-1:0] m_capture, m_data, e_sd;
    logic [15:0]   m_count;
    bit            pv0, pv1;
    logic [DW-1:0] pd0, pd1;
    bit            e_acc, e_err, e_lock, e_upd_phase, e_done, e_ack, e_wren_b, e_sv, h_in;
    logic [AW-1:0] e_lock_addr;

    always @(negedge clock) begin
        if (!reset_n) begin
            m_active = 0; m_writing = 0; m_age = 0; m_count = '0;
            pv0 = 0; pv1 = 0; e_sd = '0;
            check("rst_req_ready", 64'(req_ready), 64'd1);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_state_valid", 64'(state_valid), 64'd0);
            check("rst_state_data", state_data, 64'd0);
            check("rst_wren_a", 64'(ram_wren_a), 64'd0);
            check("rst_rvalid", 64'(host_rvalid), 64'd0);
            check("rst_count", 64'(update_count), 64'd0);
        end else begin
            e_acc       = !m_active && req_valid && (int'(req_chan) < DEPTH);
            e_err       = !m_active && req_valid && !(int'(req_chan) < DEPTH);
            e_lock      = e_acc || m_active;
            e_lock_addr = e_acc ? req_chan : m_chan;
            e_sv        = m_active && !m_writing && (m_age == 4);
            if (e_sv) e_sd = m_capture;
            e_upd_phase = m_active && !m_writing && (m_age >= 4);
            e_done      = m_writing || (e_upd_phase && upd_valid && upd_discard);
            e_ack       = host_req && !(e_lock && (host_addr == e_lock_addr));
            h_in        = int'(host_addr) < DEPTH;
            e_wren_b    = e_ack && host_wr && h_in;

            check("m_req_ready", 64'(req_ready), 64'(!m_active));
            check("m_busy", 64'(busy), 64'(m_active));
            check("m_req_err", 64'(req_err), 64'(e_err));
            check("m_state_valid", 64'(state_valid), 64'(e_sv));
            check("m_state_data", state_data, e_sd);
            check("m_done", 64'(done), 64'(e_done));
            check("m_wren_a", 64'(ram_wren_a), 64'(m_writing));
            if (m_writing) begin
                check("m_addr_a_wr", 64'(ram_address_a), 64'(m_chan));
                check("m_data_a", ram_data_a, m_data);
            end
            if (m_active && m_age == 1) check("m_addr_a_rd", 64'(ram_address_a), 64'(m_chan));
            check("m_host_ack", 64'(host_ack), 64'(e_ack));
            check("m_wren_b", 64'(ram_wren_b), 64'(e_wren_b));
            if (e_ack) check("m_addr_b", 64'(ram_address_b), 64'(host_addr));
            if (e_wren_b) check("m_data_b", ram_data_b, host_wdata);
            check("m_rvalid", 64'(host_rvalid), 64'(pv1));
            if (pv1) check("m_rdata", host_rdata, pd1);
            check("m_count", 64'(update_count), 64'(m_count));

            // advance the model to the next cycle
            pv1 = pv0; pd1 = pd0;
            pv0 = e_ack && !host_wr;
            pd0 = h_in ? gold[host_addr] : 64'd0;
            if (m_writing) begin
                gold[m_chan] = m_data;
                m_count   = m_count + 16'd1;
                m_active  = 0;
                m_writing = 0;
            end else if (e_upd_phase && upd_valid) begin
                if (upd_discard) m_active = 0;
                else begin
                    m_writing = 1;
                    m_data    = upd_data;
                end
            end else if (m_active) begin
                m_age++;
            end
            if (e_acc) begin
                m_active  = 1;
                m_age     = 1;
                m_chan    = req_chan;
                m_capture = gold[req_chan];
            end
            if (e_wren_b) gold[host_addr] = host_wdata;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        req_valid = 0; req_chan = '0; upd_valid = 0; upd_discard = 0; upd_data = '0;
        host_req = 0; host_wr = 0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc(); clear_inputs();
        host_req = 1; host_wr = 1; host_addr = a; host_wdata = d;
        smp();
        check("hw_ack", 64'(host_ack), 64'd1);
        cyc(); clear_inputs();
    endtask

    task automatic host_read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        cyc(); clear_inputs();
        host_req = 1; host_wr = 0; host_addr = a;
        smp();
        check({name, "_ack"}, 64'(host_ack), 64'd1);
        check({name, "_wren_b"}, 64'(ram_wren_b), 64'd0);
        cyc(); clear_inputs(); smp();
        cyc(); smp();
        check({name, "_rvalid"}, 64'(host_rvalid), 64'd1);
        check({name, "_rdata"}, host_rdata, exp);
    endtask

    task automatic accept(input logic [AW-1:0] ch);
        cyc(); clear_inputs();
        req_valid = 1; req_chan = ch;
        smp();
        check("acc_ready", 64'(req_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        int waited;
        int rv_cnt;
        clear_inputs();
        reset_n = 0;
        repeat (3) begin cyc(); smp(); end
        cyc(); reset_n = 1; smp();
        check("init_ready", 64'(req_ready), 64'd1);
        check("init_count", 64'(update_count), 64'd0);

        // T1: basic RMW with minimum latency
        host_write(4'd3, 64'h1111);
        accept(4'd3);
        for (int k = 1; k <= 5; k++) begin
            cyc(); clear_inputs();
            if (k == 4) begin upd_valid = 1; upd_data = 64'h2222; end
            smp();
            if (k == 4) begin
                check("t1_state_valid", 64'(state_valid), 64'd1);
                check("t1_state_data", state_data, 64'h1111);
            end
            if (k == 5) begin
                check("t1_wren_a", 64'(ram_wren_a), 64'd1);
                check("t1_addr_a", 64'(ram_address_a), 64'd3);
                check("t1_data_a", ram_data_a, 64'h2222);
                check("t1_done", 64'(done), 64'd1);
            end
        end
        cyc(); smp();
        check("t1_count", 64'(update_count), 64'd1);
        host_read_check("t1_rd3", 4'd3, 64'h2222);

        // T2: host read of the locked channel stalls until IDLE
        accept(4'd3);
        waited = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(); clear_inputs();
            host_req = 1; host_addr = 4'd3;
            if (k == 6) begin upd_valid = 1; upd_data = 64'h3333; end
            smp();
            if (host_ack) break;
            waited++;
        end
        check("t2_stall_cycles", 64'(waited), 64'd7);
        cyc(); clear_inputs(); smp();
        cyc(); smp();
        check("t2_rvalid", 64'(host_rvalid), 64'd1);
        check("t2_rdata", host_rdata, 64'h3333);

        // T3: concurrent back-to-back host reads of another channel
        host_write(4'd5, 64'h5555);
        accept(4'd3);
        rv_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc(); clear_inputs();
            if (k <= 4) begin host_req = 1; host_addr = 4'd5; end
            if (k == 5) begin upd_valid = 1; upd_discard = 1; end
            smp();
            if (k <= 4) check("t3_ack", 64'(host_ack), 64'd1);
            if (k >= 3 && k <= 6) begin
                check("t3_rdata", host_rdata, 64'h5555);
                if (host_rvalid) rv_cnt++;
            end
            if (k == 7) check("t3_rvalid_end", 64'(host_rvalid), 64'd0);
        end
        check("t3_rvalid_cycles", 64'(rv_cnt), 64'd4);

        // T4: same-cycle collision, tracking request wins; then discard
        cyc(); clear_inputs();
        req_valid = 1; req_chan = 4'd7;
        host_req = 1; host_wr = 1; host_addr = 4'd7; host_wdata = 64'h7777;
        smp();
        check("t4_ready", 64'(req_ready), 64'd1);
        check("t4_ack_blocked", 64'(host_ack), 64'd0);
        for (int k = 1; k <= 5; k++) begin
            cyc(); req_valid = 0;
            upd_valid = (k == 4); upd_discard = (k == 4);
            smp();
            if (k == 4) begin
                check("t4_done", 64'(done), 64'd1);
                check("t4_no_wren_a", 64'(ram_wren_a), 64'd0);
            end
            if (k == 5) begin
                check("t4_ack_after", 64'(host_ack), 64'd1);
                check("t4_wren_b", 64'(ram_wren_b), 64'd1);
            end
        end
        cyc(); clear_inputs(); smp();
        check("t4_count", 64'(update_count), 64'd2);
        host_read_check("t4_rd7", 4'd7, 64'h7777);

        // T5: out-of-range request and host access
        cyc(); clear_inputs();
        req_valid = 1; req_chan = 4'd13;
        smp();
        check("t5_req_err", 64'(req_err), 64'd1);
        cyc(); clear_inputs(); smp();
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_req_err_off", 64'(req_err), 64'd0);
        host_read_check("t5_rd13", 4'd13, 64'd0);
        cyc(); clear_inputs();
        host_req = 1; host_wr = 1; host_addr = 4'd13; host_wdata = 64'hBAD;
        smp();
        check("t5_wr13_ack", 64'(host_ack), 64'd1);
        check("t5_wr13_wren_b", 64'(ram_wren_b), 64'd0);

        // T6: reset during UPDATE abandons the RMW
        accept(4'd2);
        for (int k = 1; k <= 4; k++) begin cyc(); clear_inputs(); smp(); end
        check("t6_state_valid", 64'(state_valid), 64'd1);
        cyc(); reset_n = 0; upd_valid = 1; upd_data = 64'hDEAD;
        smp();
        check("t6_busy_rst", 64'(busy), 64'd0);
        check("t6_wren_a_rst", 64'(ram_wren_a), 64'd0);
        cyc(); smp();
        cyc(); reset_n = 1; clear_inputs(); smp();
        check("t6_ready", 64'(req_ready), 64'd1);
        check("t6_count", 64'(update_count), 64'd0);
        host_read_check("t6_rd2", 4'd2, 64'h0C0F_FEE0_0000_0002);

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            cyc();
            req_valid   = ($urandom_range(0, 3) == 0);
            req_chan    = AW'($urandom_range(0, 15));
            upd_valid   = ($urandom_range(0, 2) == 0);
            upd_discard = ($urandom_range(0, 3) == 0);
            upd_data    = {$urandom, $urandom};
            host_req    = ($urandom_range(0, 1) == 1);
            host_wr     = ($urandom_range(0, 1) == 1);
            host_addr   = AW'($urandom_range(0, 15));
            host_wdata  = {$urandom, $urandom};
            smp();
        end
        cyc(); clear_inputs();
        repeat (4) begin smp(); cyc(); end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
